// File: rtl/hamming_dispatch.sv
// Hamming nearest-entry search sequencer.
// Reads each stored entry in turn, hands entry^query to an external popcount
// stage, and keeps the lowest-index minimum distance seen.
package hamming_pkg;
  typedef logic [31:0] feature_t;
  typedef logic [5:0]  feature_count_t;
endpackage

module hamming_dispatch #(
  parameter type cb_data_t  = hamming_pkg::feature_t,
  parameter type cb_count_t = hamming_pkg::feature_count_t,
  parameter int  N_ENTRY    = 16,
  localparam int ADDR_W     = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  cb_data_t          query_i,
  output logic              busy,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  cb_data_t          mem_rdata,
  output logic              cb_vld,
  output cb_data_t          cb_data,
  input  logic              cb_count_vld,
  input  cb_count_t         cb_count,
  output logic              done,
  output logic [ADDR_W-1:0] best_idx,
  output cb_count_t         best_count
);

  typedef enum logic [2:0] {IDLE, RD, ISS, WAIT, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENTRY - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  cb_data_t          query;

  // Busy is a pure decode of the state register, so it has no input path.
  assign busy = (state != IDLE);

  // Search sequencer; mem_re, cb_vld and done are one-cycle registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      query      <= '0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      cb_vld     <= 1'b0;
      cb_data    <= '0;
      done       <= 1'b0;
      best_idx   <= '0;
      best_count <= '0;
    end else begin
      mem_re <= 1'b0;
      cb_vld <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= RD;
            query      <= query_i;
            idx        <= '0;
            best_idx   <= '0;
            best_count <= '1;
            // Strobe is raised on entry so it is high during the RD cycle.
            mem_re     <= 1'b1;
            mem_addr   <= '0;
          end
        end
        RD: state <= ISS;
        ISS: begin
          cb_data <= mem_rdata ^ query;
          cb_vld  <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (cb_count_vld) begin
            // Strict compare keeps the earliest index on ties.
            if (cb_count < best_count) begin
              best_count <= cb_count;
              best_idx   <= idx;
            end
            if (idx == LAST_IDX) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              mem_addr <= idx + 1'b1;
              mem_re   <= 1'b1;
              state    <= RD;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
